cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle controller for the 16-bit register/ALU datapath.
- Latches one instruction on a start pulse and decodes it. Steps the datapath through read-A, read-B, ALU and writeback.
- Drives every datapath control: readnum, writenum, write, loada, loadb, loadc, asel, bsel, vsel, shift, ALUop, sximm5, sximm8.
- Signals idle on w; the top level pulses s and waits for w.

Parameters:
- DATA_W, 16, width of sximm5/sximm8 outputs (sign-extension target).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high.
- s  input  1  start; sampled only in WAIT.
- in  input  16  instruction word.
- w  output  1  high only in WAIT.
- readnum  output  3  regfile read index.
- writenum  output  3  regfile write index.
- write  output  1  regfile write enable.
- loada, loadb, loadc  output  1 each  pipeline register loads.
- asel, bsel  output  1 each  A zero-select, B imm5-select.
- vsel  output  2  writeback mux: 00 mdata, 01 sximm8, 10 PC, 11 C.
- shift  output  2  shifter control.
- ALUop  output  2  00 ADD, 01 CMP (updates status), 10 AND, 11 MVN.
- sximm5, sximm8  output  DATA_W  sign-extended immediates.
- err  output  1  illegal-instruction flag (see Optional Feature).

Behaviour:
- Reset: one clock with reset high forces state WAIT. Reset has priority over every transition.
- Reset output values: w=1; all loads, write, asel, bsel, err = 0; vsel=00; ALUop=00; shift=00; readnum=writenum=000.
- Instruction register IR (16b): loaded from in on the edge where state==WAIT and s==1; held otherwise.
- Decode fields: opc=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Immediates: sximm8=sign-extend IR[7:0]; sximm5=sign-extend IR[4:0]. Both are continuous from IR.
- Instructions:
  - MOVI opc=110 op=10
  - MOV opc=110 op=00
  - ADD opc=101 op=00
  - CMP opc=101 op=01
  - AND opc=101 op=10
  - MVN opc=101 op=11
  - Any other opc/op is illegal.
- States: WAIT, DECODE, GET_A, GET_B, ALU, WB_REG, WB_IMM, HALT (HALT only with feature).
- Transitions:
  - WAIT -> DECODE if s, else stay.
  - DECODE: MOVI -> WB_IMM; MOV, MVN -> GET_B; ADD, AND, CMP -> GET_A; illegal -> WAIT.
  - GET_A -> GET_B -> ALU.
  - ALU: CMP -> WAIT; others -> WB_REG.
  - WB_REG -> WAIT; WB_IMM -> WAIT.
- Outputs are Moore, combinational from state+IR. Defaults are the reset values; w=0 outside WAIT.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU: shift=sh, bsel=0, ALUop per op; asel=1 for MOV/MVN, else 0; loadc=1 except CMP.
  - WB_REG: vsel=11, writenum=Rd, write=1.
  - WB_IMM: vsel=01, writenum=Rn, write=1.
- ALUop=01 appears only in the ALU state of CMP. Every other cycle drives 00 so the status flags never update spuriously.
- Latency, in edges from the s-sampling edge to w=1: MOVI 3; MOV, MVN, CMP 5; ADD, AND 6.
- s is ignored outside WAIT. in may change freely after the capture edge.
- write is gated with ~reset. Reset asserted in WB_* commits no register write on that edge.
- Reset mid-instruction: the next edge returns to WAIT. IR is retained but unused.

Optional Feature:
- Macro: CPU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal decode moves DECODE -> HALT. HALT holds with err=1 and w=0, exits only via reset, and ignores s.
- Undefined: an illegal decode goes DECODE -> WAIT as a 2-edge NOP. No HALT state; err tied 0.

Test Plan:
- Reset 2 cycles, then idle -> w=1, write=0, ALUop=00 every cycle, no transition while s=0.
- in=16'hD0FB (MOVI R0,#-5), s pulse -> WB_IMM has writenum=000, vsel=01, write=1, sximm8=16'hFFFB; w=1 on third edge.
- in=16'hA2A8 (ADD R5,R2,R0,LSL#1) -> GET_A readnum=010 loada; GET_B readnum=000 loadb; ALU shift=01 ALUop=00 loadc; WB_REG writenum=101 vsel=11; 6 edges.
- in=16'hA920 (CMP R1,R0) -> ALUop=01 for exactly one cycle, loadc=0 and write=0 throughout, w=1 after 5 edges.
- Reset asserted during WB_REG of ADD -> write=0 on that edge, state WAIT, w=1 next cycle.
- in=16'hE000 (illegal) -> with macro: HALT, err=1, s ignored until reset. Without: WAIT after 2 edges, err=0, no load or write pulses.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle controller for the 16-bit register/ALU datapath
// Optional illegal-instruction trap state: define CPU_SEQ_ILLEGAL_TRAP_EN.
module cpu_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [15:0]       in,
    output logic              w,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_GET_A  = 3'd2,
        ST_GET_B  = 3'd3,
        ST_ALU    = 3'd4,
        ST_WB_REG = 3'd5,
        ST_WB_IMM = 3'd6
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        ,
        ST_HALT   = 3'd7
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_movi, is_mov, is_add, is_cmp, is_and, is_mvn;
    logic       write_raw;

    assign opc = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    assign is_movi = (opc == 3'b110) && (op == 2'b10);
    assign is_mov  = (opc == 3'b110) && (op == 2'b00);
    assign is_add  = (opc == 3'b101) && (op == 2'b00);
    assign is_cmp  = (opc == 3'b101) && (op == 2'b01);
    assign is_and  = (opc == 3'b101) && (op == 2'b10);
    assign is_mvn  = (opc == 3'b101) && (op == 2'b11);

    assign sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            ST_WAIT: begin
                if (s) begin
                    ir_d    = in;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_movi)
                    state_d = ST_WB_IMM;
                else if (is_mov || is_mvn)
                    state_d = ST_GET_B;
                else if (is_add || is_and || is_cmp)
                    state_d = ST_GET_A;
                else
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
`else
                    state_d = ST_WAIT;
`endif
            end
            ST_GET_A:  state_d = ST_GET_B;
            ST_GET_B:  state_d = ST_ALU;
            ST_ALU:    state_d = is_cmp ? ST_WAIT : ST_WB_REG;
            ST_WB_REG: state_d = ST_WAIT;
            ST_WB_IMM: state_d = ST_WAIT;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            ST_HALT:   state_d = ST_HALT;
`endif
            default:   state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // ALUop stays ADD outside the ALU state so status flags only move on CMP.
    always_comb begin
        w         = 1'b0;
        readnum   = 3'b000;
        writenum  = 3'b000;
        write_raw = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 2'b00;
        shift     = 2'b00;
        ALUop     = 2'b00;
        err       = 1'b0;
        unique case (state_q)
            ST_WAIT: w = 1'b1;
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_ALU: begin
                shift = sh;
                ALUop = op;
                asel  = is_mov || is_mvn;
                loadc = !is_cmp;
            end
            ST_WB_REG: begin
                vsel      = 2'b11;
                writenum  = rd;
                write_raw = 1'b1;
            end
            ST_WB_IMM: begin
                vsel      = 2'b01;
                writenum  = rn;
                write_raw = 1'b1;
            end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            ST_HALT: err = 1'b1;
`endif
            default: ;
        endcase
    end

    // A reset landing on a writeback edge must not commit the register write.
    assign write = write_raw & ~reset;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, asel, bsel, err;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm5, sximm8;

    int total = 0;
    int bad   = 0;

    cpu_sequencer #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm5(sximm5), .sximm8(sximm8), .err(err)
    );

    always #5 clk = ~clk;

    logic [19:0] dut_ctl;
    assign dut_ctl = {w, readnum, writenum, write, loada, loadb, loadc,
                      asel, bsel, vsel, shift, ALUop, err};

    function automatic logic [19:0] ctl(
        input logic w_e, input logic [2:0] rn_e, input logic [2:0] wn_e,
        input logic wr_e, input logic la_e, input logic lb_e, input logic lc_e,
        input logic as_e, input logic bs_e, input logic [1:0] vs_e,
        input logic [1:0] sh_e, input logic [1:0] op_e, input logic er_e);
        return {w_e, rn_e, wn_e, wr_e, la_e, lb_e, lc_e, as_e, bs_e,
                vs_e, sh_e, op_e, er_e};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] idle_c, busy_c;

    initial begin
        idle_c = ctl(1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        busy_c = ctl(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        reset = 1'b1; s = 1'b0; in = 16'h0000;
        step(); step();
        check("reset_ctl", dut_ctl, idle_c);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ctl", dut_ctl, idle_c);
        end

        // MOVI R0,#-5
        in = 16'hD0FB; s = 1'b1;
        step(); s = 1'b0; in = 16'h1234;
        check("movi_decode", dut_ctl, busy_c);
        step();
        check("movi_wb_imm", dut_ctl, ctl(0, 3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
        check("movi_sximm8", sximm8, 16'hFFFB);
        check("movi_sximm5", sximm5, 16'hFFFB);
        step();
        check("movi_done", dut_ctl, idle_c);

        // ADD R5,R2,R0,LSL#1
        in = 16'hA2A8; s = 1'b1;
        step(); s = 1'b0;
        check("add_decode", dut_ctl, busy_c);
        check("add_sximm5", sximm5, 16'h0008);
        check("add_sximm8", sximm8, 16'hFFA8);
        step();
        check("add_get_a", dut_ctl, ctl(0, 3'd2, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step();
        check("add_get_b", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step();
        check("add_alu", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0));
        step();
        check("add_wb_reg", dut_ctl, ctl(0, 3'd0, 3'd5, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
        step();
        check("add_done", dut_ctl, idle_c);

        // CMP R1,R0 with s held high while busy (must be ignored)
        in = 16'hA920; s = 1'b1;
        step(); in = 16'hFFFF;
        check("cmp_decode", dut_ctl, busy_c);
        step();
        check("cmp_get_a", dut_ctl, ctl(0, 3'd1, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step();
        check("cmp_get_b", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step(); s = 1'b0;
        check("cmp_alu", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0));
        step();
        check("cmp_done", dut_ctl, idle_c);
        step();
        check("cmp_stays_idle", dut_ctl, idle_c);

        // MOV R3,R1,LSR-style sh=10
        in = 16'hC071; s = 1'b1;
        step(); s = 1'b0;
        check("mov_decode", dut_ctl, busy_c);
        step();
        check("mov_get_b", dut_ctl, ctl(0, 3'd1, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step();
        check("mov_alu", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0));
        step();
        check("mov_wb_reg", dut_ctl, ctl(0, 3'd0, 3'd3, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
        step();
        check("mov_done", dut_ctl, idle_c);

        // MVN R2,R4
        in = 16'hB844; s = 1'b1;
        step(); s = 1'b0;
        step();
        check("mvn_get_b", dut_ctl, ctl(0, 3'd4, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step();
        check("mvn_alu", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b11, 0));
        step();
        check("mvn_wb_reg", dut_ctl, ctl(0, 3'd0, 3'd2, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
        step();
        check("mvn_done", dut_ctl, idle_c);

        // AND R4,R3,R5,sh=11
        in = 16'hB39D; s = 1'b1;
        step(); s = 1'b0;
        step();
        check("and_get_a", dut_ctl, ctl(0, 3'd3, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step();
        check("and_get_b", dut_ctl, ctl(0, 3'd5, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step();
        check("and_alu", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b11, 2'b10, 0));
        step();
        check("and_wb_reg", dut_ctl, ctl(0, 3'd0, 3'd4, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
        step();
        check("and_done", dut_ctl, idle_c);

        // Reset during WB_REG of ADD
        in = 16'hA2A8; s = 1'b1;
        step(); s = 1'b0;
        step(); step(); step(); step();
        check("rst_wb_pre_write", write, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_wb_write_gated", write, 1'b0);
        step();
        check("rst_wb_to_wait", dut_ctl, idle_c);
        reset = 1'b0;
        step();
        check("rst_wb_idle", dut_ctl, idle_c);

        // Illegal opcodes
        in = 16'hE000; s = 1'b1;
        step(); s = 1'b0;
        check("ill_decode", dut_ctl, busy_c);
        step();
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        check("ill_halt", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1));
        s = 1'b1;
        step(); step();
        check("ill_halt_hold", dut_ctl, ctl(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1));
        s = 1'b0; reset = 1'b1;
        step();
        check("ill_halt_reset", dut_ctl, idle_c);
        reset = 1'b0;
`else
        check("ill_nop_wait", dut_ctl, idle_c);
`endif
        in = 16'hC800; s = 1'b1;
        step(); s = 1'b0;
        check("ill2_decode", dut_ctl, busy_c);
        step();
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        check("ill2_halt", err, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ill2_reset", dut_ctl, idle_c);
`else
        check("ill2_nop_wait", dut_ctl, idle_c);
`endif
        step();
        check("final_idle", dut_ctl, idle_c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
